cache_line_fill_mem: RTL and testbench
======================================

// Module: cache_line_fill_mem
// PURPOSE
//   Backing-memory responder on the far side of the direct-mapped cache's miss path.
//   Read request: returns one full cache line as a burst of word beats, critical word first.
//   Write request: posted, single word, no response.
//   Fixed, parameterised access latency, so the bench sees realistic miss penalties.
// PARAMETERS
//   ADDR_W      8   byte/word address width; memory depth = 2**ADDR_W words
//   DATA_W      8   word width
//   LINE_WORDS  4   words per cache line; power of two, >= 2
//   LATENCY     3   acceptance-to-first-beat delay in clocks; >= 1
// PORTS
//   clk        in   1        single clock, rising edge
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   1        request present
//   req_ready  out  1        request accepted on an edge where valid && ready
//   req_we     in   1        1 = write, 0 = line read
//   req_addr   in   ADDR_W   word address (read: requested/critical word)
//   req_wdata  in   DATA_W   write data (ignored for reads)
//   rsp_valid  out  1        response beat present
//   rsp_ready  in   1        beat consumed on an edge where valid && ready
//   rsp_data   out  DATA_W   beat data
//   rsp_last   out  1        final beat of the line
//   busy       out  1        high whenever not IDLE
// BEHAVIOUR
//   Reset: state IDLE, rsp_valid=0, rsp_last=0, rsp_data=0, busy=0, req_ready=1 after the reset edge.
//   Reset does not clear the memory array. Power-up contents: mem[i] = i[DATA_W-1:0].
//   FSM: IDLE -> WAIT on read accept; WAIT -> BURST when latency count expires;
//     BURST -> IDLE on last-beat handshake. Writes never leave IDLE.
//   req_ready = (state == IDLE). Requests in other states stay pending (not dropped).
//   Address changes on a pending, unaccepted request have no effect.
//   Write: mem[req_addr] <= req_wdata on the accept edge; visible to any later read, including the next cycle.
//   Read: base = req_addr with low log2(LINE_WORDS) bits cleared; off = low bits.
//     Beat k (0..LINE_WORDS-1) carries mem[base | ((off+k) mod LINE_WORDS)]; offset wraps within the line.
//   Latency: request accepted at edge E -> rsp_valid first high after edge E+LATENCY.
//     LATENCY=1 -> valid in the cycle after acceptance.
//   rsp_last = 1 only with beat LINE_WORDS-1.
//   Stall (rsp_valid && !rsp_ready): rsp_data and rsp_last held stable, beat counter frozen.
//   Advance: on each handshake edge, the next beat is loaded, so back-to-back beats are one per clock.
//   After the last-beat handshake edge: rsp_valid=0, state IDLE, req_ready=1 in that same following cycle.
//   rst mid-WAIT/BURST: on that edge rsp_valid=0, rsp_last=0, state IDLE, counters cleared;
//     the in-flight burst is abandoned, not resumed.
//   Counters: latency counter $clog2(LATENCY+1) bits; beat counter $clog2(LINE_WORDS) bits.
//     Both wrap naturally, with no overflow past terminal count.
//   rsp_data is registered. The array read is combinational from the registered next-beat address.
// STRUCTURE
//   Package cache_mem_pkg: fill_state_t enum {IDLE, WAIT, BURST}, localparam OFF_W = $clog2(LINE_WORDS).
//   Sub-module mem_array: 2**ADDR_W x DATA_W register file, one sync write port, one comb read port.
//     Holds the power-up init pattern.
//   Top level holds the FSM, counters, the address-wrap logic and the response register.
// TESTING (LINE_WORDS=4, LATENCY=3 unless noted)
//   1. rst high for 5 clocks, req_valid=0 -> rsp_valid=0, rsp_last=0, busy=0, req_ready=1.
//   2. Read 0x02, rsp_ready=1 -> first beat after 3 edges; 0x02,0x03,0x00,0x01; rsp_last on 0x01;
//      req_ready=1 in the next cycle.
//   3. Read 0x04, rsp_ready pattern 1,0,0,1,1,0,1 -> data 0x04..0x07 in order;
//      each value held through its stall cycles; exactly 4 handshakes.
//   4. Write 0x03<-0xA5, then read 0x03 next cycle -> A5,00,01,02; rsp_last on 02.
//   5. Second read 0x08 raised during the previous burst -> req_ready=0 until the burst ends;
//      accepted on the first IDLE edge; beats 08,09,0A,0B.
//   6. rst for 1 clock after 2 beats of read 0x03 -> rsp_valid=0 the next cycle;
//      re-read 0x03 returns the full 4 beats A5,00,01,02 (memory preserved).

Source files
------------

// File: rtl/cache_line_fill_mem_pkg.sv
// ============================================================================
// Module : cache_mem_pkg
// Brief  : Shared types and default sizing for the cache line-fill memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package cache_mem_pkg;

   localparam int DEF_ADDR_W     = 8;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_LATENCY    = 3;
   localparam int OFF_W          = $clog2(DEF_LINE_WORDS);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      BURST = 2'd2
   } fill_state_t;

endpackage

`default_nettype wire

// File: rtl/cache_line_fill_mem_if.sv
// ============================================================================
// Module : cache_line_fill_mem_if
// Brief  : Request/response bus between the cache miss path and backing memory.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface cache_line_fill_mem_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data;
   logic              rsp_last;
   logic              busy;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_last, busy
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_last, busy
   );
endinterface

`default_nettype wire

// File: rtl/cache_line_fill_mem_mem_array.sv
// ============================================================================
// Module : mem_array
// Brief  : Register-file backing store, one sync write port, one comb read port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_array #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  wire logic              clk,
   input  wire logic              we_i,
   input  wire logic [ADDR_W-1:0] waddr_i,
   input  wire logic [DATA_W-1:0] wdata_i,
   input  wire logic [ADDR_W-1:0] raddr_i,
   output logic      [DATA_W-1:0] rdata_o
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] words [DEPTH];

   // Each word powers up holding its own index; reset never touches contents.
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      logic [DATA_W-1:0] word_q = DATA_W'(i);

      always_ff @(posedge clk) begin
         if (we_i && (waddr_i == ADDR_W'(i))) begin
            word_q <= wdata_i;
         end
      end

      assign words[i] = word_q;
   end

   assign rdata_o = words[raddr_i];

endmodule

`default_nettype wire

// File: rtl/cache_line_fill_mem.sv
// ============================================================================
// Module : cache_line_fill_mem
// Brief  : Fixed-latency line-fill responder, critical word first, posted writes.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module cache_line_fill_mem
   import cache_mem_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int LATENCY    = DEF_LATENCY
) (
   input wire logic             clk,
   input wire logic             rst,
   cache_line_fill_mem_if.slave bus
);
   localparam int BEAT_W = $clog2(LINE_WORDS);
   localparam int LAT_W  = $clog2(LATENCY + 1);

   fill_state_t       state_q, state_d;
   logic [LAT_W-1:0]  lat_q, lat_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_last_q, rsp_last_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

   logic              mem_we;
   logic              load_beat;
   logic [DATA_W-1:0] mem_rdata;

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (bus.req_addr),
      .wdata_i (bus.req_wdata),
      .raddr_i (rd_addr_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         lat_q       <= '0;
         beat_q      <= '0;
         rd_addr_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_last_q  <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         beat_q      <= beat_d;
         rd_addr_q   <= rd_addr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= rsp_last_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      beat_d      = beat_q;
      rd_addr_d   = rd_addr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_last_d  = rsp_last_q;
      rsp_data_d  = rsp_data_q;
      mem_we      = 1'b0;
      load_beat   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (bus.req_we) begin
                  mem_we = 1'b1;
               end else begin
                  state_d   = WAIT;
                  rd_addr_d = bus.req_addr;
                  lat_d     = '0;
                  beat_d    = '0;
               end
            end
         end
         WAIT: begin
            if (lat_q == LAT_W'(LATENCY - 1)) begin
               state_d   = BURST;
               lat_d     = '0;
               load_beat = 1'b1;
            end else begin
               lat_d = lat_q + 1'b1;
            end
         end
         BURST: begin
            if (rsp_valid_q && bus.rsp_ready) begin
               if (rsp_last_q) begin
                  state_d     = IDLE;
                  rsp_valid_d = 1'b0;
                  rsp_last_d  = 1'b0;
               end else begin
                  load_beat = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // rd_addr_q always points at the beat to load next; only the offset bits wrap.
      if (load_beat) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = mem_rdata;
         rsp_last_d  = (beat_q == BEAT_W'(LINE_WORDS - 1));
         beat_d      = beat_q + 1'b1;
         rd_addr_d   = {rd_addr_q[ADDR_W-1:BEAT_W], rd_addr_q[BEAT_W-1:0] + 1'b1};
      end
   end

   always_comb begin
      bus.req_ready = (state_q == IDLE);
      bus.busy      = (state_q != IDLE);
      bus.rsp_valid = rsp_valid_q;
      bus.rsp_last  = rsp_last_q;
      bus.rsp_data  = rsp_data_q;
   end

endmodule

`default_nettype wire

// File: tb/tb_cache_line_fill_mem.sv
// ============================================================================
// Module : tb_cache_line_fill_mem
// Brief  : Directed self-checking bench for the line-fill memory responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_cache_line_fill_mem;
   import cache_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   cache_line_fill_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

   cache_line_fill_mem #(
      .ADDR_W     (8),
      .DATA_W     (8),
      .LINE_WORDS (4),
      .LATENCY    (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Present a request and return #1 after the edge that accepts it.
   task automatic start_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata);
      int n = 0;
      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      while (!bus.req_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 50) chk_eq("accept_timeout", 32'(n), 32'd0);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
   endtask

   // Consume nb beats with the given rsp_ready pattern (ones once it runs out).
   task automatic collect(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                          input logic [7:0] e3, input logic [15:0] pat, input int npat,
                          input int nb, input bit raise, input logic [7:0] naddr,
                          input string tag);
      logic [7:0] exp [4];
      int   lat, beat, cyc, idx, rdy_bad;
      logic rdy;
      exp = '{e0, e1, e2, e3};
      lat = 0; beat = 0; cyc = 0; idx = 0; rdy_bad = 0;
      while (!bus.rsp_valid && lat < 20) begin
         @(posedge clk); #1; lat++;
      end
      chk_eq({tag, "_latency"}, 32'(lat), 32'd3);
      while (beat < nb && cyc < 40) begin
         rdy = (idx < npat) ? pat[idx] : 1'b1;
         idx++;
         bus.rsp_ready = rdy;
         if (raise && cyc == 0) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b0;
            bus.req_addr  = naddr;
         end
         chk_eq($sformatf("%s_valid%0d", tag, cyc), 32'(bus.rsp_valid), 32'd1);
         chk_eq($sformatf("%s_data%0d", tag, cyc), 32'(bus.rsp_data), 32'(exp[beat]));
         chk_eq($sformatf("%s_last%0d", tag, cyc), 32'(bus.rsp_last), 32'(beat == 3));
         if (bus.req_ready) rdy_bad++;
         if (bus.rsp_valid && rdy) beat++;
         @(posedge clk); #1;
         cyc++;
      end
      chk_eq({tag, "_handshakes"}, 32'(beat), 32'(nb));
      chk_eq({tag, "_ready_in_burst"}, 32'(rdy_bad), 32'd0);
      if (nb == 4) begin
         chk_eq({tag, "_end_valid"}, 32'(bus.rsp_valid), 32'd0);
         chk_eq({tag, "_end_ready"}, 32'(bus.req_ready), 32'd1);
         chk_eq({tag, "_end_busy"},  32'(bus.busy),      32'd0);
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.rsp_ready = 1'b1;

      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      chk_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk_eq("reset_rsp_last",  32'(bus.rsp_last),  32'd0);
      chk_eq("reset_rsp_data",  32'(bus.rsp_data),  32'd0);
      chk_eq("reset_busy",      32'(bus.busy),      32'd0);
      chk_eq("reset_req_ready", 32'(bus.req_ready), 32'd1);

      // Critical word first with wrap inside the line.
      start_req(1'b0, 8'h02, 8'h00);
      chk_eq("rd02_busy",      32'(bus.busy),      32'd1);
      chk_eq("rd02_req_ready", 32'(bus.req_ready), 32'd0);
      collect(8'h02, 8'h03, 8'h00, 8'h01, 16'h0000, 0, 4, 1'b0, 8'h00, "rd02");

      // Back-pressure 1,0,0,1,1,0,1.
      start_req(1'b0, 8'h04, 8'h00);
      collect(8'h04, 8'h05, 8'h06, 8'h07, 16'b1011001, 7, 4, 1'b0, 8'h00, "rd04");

      // Posted write then immediate read of the same word.
      start_req(1'b1, 8'h03, 8'hA5);
      chk_eq("wr_busy",      32'(bus.busy),      32'd0);
      chk_eq("wr_req_ready", 32'(bus.req_ready), 32'd1);
      start_req(1'b0, 8'h03, 8'h00);
      collect(8'hA5, 8'h00, 8'h01, 8'h02, 16'h0000, 0, 4, 1'b0, 8'h00, "rd03");

      // Read 0x08 raised while the 0x10 burst is still running.
      start_req(1'b0, 8'h10, 8'h00);
      collect(8'h10, 8'h11, 8'h12, 8'h13, 16'h0000, 0, 4, 1'b1, 8'h08, "rd10");
      start_req(1'b0, 8'h08, 8'h00);
      collect(8'h08, 8'h09, 8'h0A, 8'h0B, 16'h0000, 0, 4, 1'b0, 8'h00, "rd08");

      // Reset in the middle of a burst, then a clean re-read.
      start_req(1'b0, 8'h03, 8'h00);
      collect(8'hA5, 8'h00, 8'h01, 8'h02, 16'h0000, 0, 2, 1'b0, 8'h00, "rdrst");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk_eq("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk_eq("midrst_rsp_last",  32'(bus.rsp_last),  32'd0);
      chk_eq("midrst_busy",      32'(bus.busy),      32'd0);
      chk_eq("midrst_req_ready", 32'(bus.req_ready), 32'd1);
      start_req(1'b0, 8'h03, 8'h00);
      collect(8'hA5, 8'h00, 8'h01, 8'h02, 16'h0000, 0, 4, 1'b0, 8'h00, "rerd03");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
